// File: rtl/spike_log_pkg.sv
// spike_log_pkg: default sizing constants shared by the output spike logger files.
package spike_log_pkg;
    localparam int DEF_NUM_OUT    = 2;
    localparam int DEF_TS_WIDTH   = 12;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_CNT_WIDTH  = 8;
    localparam int EVT_W          = DEF_TS_WIDTH + DEF_NUM_OUT;
endpackage

// File: rtl/output_spike_logger_if.sv
// output_spike_logger_if: host readout port of the event FIFO (FWFT head plus pop request).
interface output_spike_logger_if
    import spike_log_pkg::*;
#(
    parameter int W = EVT_W
);
    logic         rd_en;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    modport master (output rd_en, input rd_data, input rd_valid);
    modport slave  (input rd_en, output rd_data, output rd_valid);
endinterface

// File: rtl/spike_event_fifo.sv
// spike_event_fifo: count-based FWFT FIFO; head reads as zero while empty.
module spike_event_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 8
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;
    assign empty   = cnt == '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty;
    // a pop frees the slot, so a push into a full FIFO still lands when both happen together
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rp];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/output_spike_logger.sv
// output_spike_logger: timestamps firing timesteps into an event FIFO and
// produces windowed per-neuron spike-rate counts.
module output_spike_logger
    import spike_log_pkg::*;
#(
    parameter int NUM_OUT    = DEF_NUM_OUT,
    parameter int TS_WIDTH   = DEF_TS_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
)(
    input  logic                          system_clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          delay_clk,
    input  logic [NUM_OUT-1:0]            output_spikes,
    input  logic [7:0]                    window_len,
    input  logic                          clear_overflow,
    output_spike_logger_if.slave          rd,
    output logic                          fifo_full,
    output logic                          overflow,
    output logic [NUM_OUT*CNT_WIDTH-1:0]  spike_count,
    output logic                          count_valid
);
    logic                 dclk_q, tick, push, empty, cnt_en, win_end;
    logic [TS_WIDTH-1:0]  ts;
    logic [7:0]           wcnt;
    logic [CNT_WIDTH-1:0] acc    [NUM_OUT];
    logic [CNT_WIDTH-1:0] acc_nx [NUM_OUT];
    assign tick        = delay_clk & ~dclk_q;
    assign push        = tick & enable & (|output_spikes);
    assign cnt_en      = tick & enable & (window_len != 8'd0);
    assign win_end     = cnt_en & (wcnt == window_len - 8'd1);
    assign rd.rd_valid = ~empty;
    spike_event_fifo #(
        .W     (TS_WIDTH + NUM_OUT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (system_clock),
        .rst   (reset),
        .push  (push),
        .pop   (rd.rd_en),
        .wdata ({ts, output_spikes}),
        .rdata (rd.rd_data),
        .full  (fifo_full),
        .empty (empty)
    );
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++)
            acc_nx[i] = &acc[i] ? acc[i] : acc[i] + CNT_WIDTH'(output_spikes[i]);
    end
    always_ff @(posedge system_clock) begin
        if (reset) begin
            dclk_q      <= 1'b0;
            ts          <= '0;
            overflow    <= 1'b0;
            wcnt        <= 8'd0;
            count_valid <= 1'b0;
            spike_count <= '0;
            for (int i = 0; i < NUM_OUT; i++) acc[i] <= '0;
        end else begin
            dclk_q      <= delay_clk;
            count_valid <= 1'b0;
            if (tick) ts <= ts + 1'b1;
            // a drop outranks a simultaneous clear so no lost event goes unreported
            if (push & fifo_full & ~rd.rd_en) overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
            if (cnt_en) begin
                wcnt        <= win_end ? 8'd0 : wcnt + 8'd1;
                count_valid <= win_end;
                for (int i = 0; i < NUM_OUT; i++) begin
                    acc[i] <= win_end ? '0 : acc_nx[i];
                    if (win_end) spike_count[i*CNT_WIDTH +: CNT_WIDTH] <= acc_nx[i];
                end
            end
        end
    end
endmodule
